// File: rtl/uart_imem_loader.sv
// uart_imem_loader
// ----------------
// Serial boot loader for the instruction RAM. A UART receiver turns the rxd
// line into bytes. A loader FSM then hunts for the sync byte, reads a word
// count, and packs data bytes into big-endian 32-bit words. It writes each
// word to the instruction RAM write port. The CPU is held in reset for the
// whole load. It is released only after a complete, error-free image, so
// fetch restarts at address 0 on a fully written program.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   rxd       UART receive line (idle high, asynchronous to clk)
//   start     one-cycle pulse that arms the loader
//   wr_en     instruction RAM write strobe (one-cycle pulse)
//   wr_addr   instruction RAM word address
//   wr_data   instruction word; only meaningful while wr_en is high
//   cpu_hold  keeps the CPU in reset while high
//   done      sticky: image loaded successfully
//   err       sticky: framing error during the load
//   word_cnt  number of words written in the current load
module uart_imem_loader #(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          ADDR_W       = 6,
  parameter logic [7:0]  HDR_BYTE     = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxd,
  input  logic              start,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_cnt
);

  localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [ADDR_W:0]   DEPTH     = (ADDR_W+1)'(1 << ADDR_W);
  localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {IDLE, WAIT_HDR, WAIT_CNT, WAIT_DATA, WRITE, DONE, ERR} state_t;

  // Receiver state
  rx_state_t        rx_state, rx_state_n;
  logic             rx_meta, rx_sync, rx_prev;
  logic [CNT_W-1:0] clk_cnt, clk_cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       rx_shift, rx_shift_n;
  logic             byte_valid, byte_valid_n;
  logic             frame_err, frame_err_n;

  // Loader state
  state_t            state, state_n;
  logic              wr_en_n, cpu_hold_n, done_n, err_n;
  logic [ADDR_W-1:0] wr_addr_n;
  logic [31:0]       wr_data_n;
  logic [ADDR_W:0]   word_cnt_n, word_cnt_inc, target, target_n;
  logic [1:0]        byte_idx, byte_idx_n;
  logic              word_full, word_full_n;

  assign word_cnt_inc = word_cnt + 1'b1;

  // Two-flop synchronizer on rxd, plus one more flop for falling-edge detection.
  // These reset to 1 so an idle line does not look like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Receiver state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state   <= RX_IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      rx_shift   <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_state   <= rx_state_n;
      clk_cnt    <= clk_cnt_n;
      bit_idx    <= bit_idx_n;
      rx_shift   <= rx_shift_n;
      byte_valid <= byte_valid_n;
      frame_err  <= frame_err_n;
    end
  end

  // Receiver next state. The start bit is re-checked at its midpoint so that
  // short glitches are rejected. Each later sample then lands one bit period
  // further on, near the middle of its bit.
  always_comb begin
    rx_state_n   = rx_state;
    clk_cnt_n    = clk_cnt;
    bit_idx_n    = bit_idx;
    rx_shift_n   = rx_shift;
    byte_valid_n = 1'b0;
    frame_err_n  = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_sync) begin
          rx_state_n = RX_START;
          clk_cnt_n  = '0;
        end
      end
      RX_START: begin
        if (clk_cnt == HALF_LAST) begin
          clk_cnt_n  = '0;
          bit_idx_n  = '0;
          rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_n  = '0;
          rx_shift_n = {rx_sync, rx_shift[7:1]};
          bit_idx_n  = bit_idx + 3'd1;
          if (bit_idx == 3'd7) rx_state_n = RX_STOP;
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_n    = '0;
          rx_state_n   = RX_IDLE;
          byte_valid_n = rx_sync;
          frame_err_n  = !rx_sync;
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // Loader state register. All outputs are registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      cpu_hold  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      word_cnt  <= '0;
      target    <= '0;
      byte_idx  <= '0;
      word_full <= 1'b0;
    end else begin
      state     <= state_n;
      wr_en     <= wr_en_n;
      wr_addr   <= wr_addr_n;
      wr_data   <= wr_data_n;
      cpu_hold  <= cpu_hold_n;
      done      <= done_n;
      err       <= err_n;
      word_cnt  <= word_cnt_n;
      target    <= target_n;
      byte_idx  <= byte_idx_n;
      word_full <= word_full_n;
    end
  end

  // Loader next state. word_full adds one cycle between the 4th byte and
  // WRITE, so wr_en rises two cycles after that byte arrives. wr_en is raised
  // on entry to WRITE and is therefore high exactly while the FSM is in WRITE.
  always_comb begin
    state_n     = state;
    wr_en_n     = 1'b0;
    wr_addr_n   = wr_addr;
    wr_data_n   = wr_data;
    cpu_hold_n  = cpu_hold;
    done_n      = done;
    err_n       = err;
    word_cnt_n  = word_cnt;
    target_n    = target;
    byte_idx_n  = byte_idx;
    word_full_n = word_full;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_n     = WAIT_HDR;
          cpu_hold_n  = 1'b1;
          done_n      = 1'b0;
          err_n       = 1'b0;
          word_cnt_n  = '0;
          wr_addr_n   = '0;
          byte_idx_n  = '0;
          word_full_n = 1'b0;
        end
      end
      WAIT_HDR, WAIT_CNT, WAIT_DATA: begin
        if (frame_err) begin
          // cpu_hold stays high so a partial image is never executed
          state_n     = ERR;
          err_n       = 1'b1;
          byte_idx_n  = '0;
          word_full_n = 1'b0;
        end else if (state == WAIT_HDR) begin
          if (byte_valid && (rx_shift == HDR_BYTE)) state_n = WAIT_CNT;
        end else if (state == WAIT_CNT) begin
          if (byte_valid) begin
            // A count of 0, or one beyond the RAM size, means "fill the RAM"
            if ((rx_shift == 8'd0) || ({24'd0, rx_shift} > 32'(DEPTH)))
              target_n = DEPTH;
            else
              target_n = (ADDR_W+1)'(rx_shift);
            state_n     = WAIT_DATA;
            byte_idx_n  = '0;
            word_full_n = 1'b0;
          end
        end else if (word_full) begin
          state_n     = WRITE;
          wr_en_n     = 1'b1;
          word_full_n = 1'b0;
        end else if (byte_valid) begin
          wr_data_n  = {wr_data[23:0], rx_shift};
          byte_idx_n = byte_idx + 2'd1;
          if (byte_idx == 2'd3) word_full_n = 1'b1;
        end
      end
      WRITE: begin
        // The address saturates so a full image leaves it at the last word
        // rather than wrapping to 0.
        wr_addr_n  = (wr_addr == ADDR_MAX) ? wr_addr : wr_addr + 1'b1;
        word_cnt_n = word_cnt_inc;
        if (word_cnt_inc == target) begin
          state_n    = DONE;
          cpu_hold_n = 1'b0;
          done_n     = 1'b1;
        end else begin
          state_n = WAIT_DATA;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_imem_loader.sv
// tb_uart_imem_loader
// -------------------
// Self-checking bench for uart_imem_loader at CLKS_PER_BIT=16. The bench
// sends UART frames bit by bit and keeps a queue of the RAM writes that the
// load rules say must occur. Each queue entry is an address and a big-endian
// word built from the bytes sent. A negedge process matches every wr_en pulse
// against the head of that queue. Directed checks cover the reset state,
// completion flags, framing errors, glitches and async reset.
module tb_uart_imem_loader;

  localparam int CPB   = 16;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst, rxd, start;
  logic          wr_en, cpu_hold, done, err;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [AW:0]   word_cnt;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;
  typedef logic [7:0] byte_q_t[$];

  wr_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_wr_en = 1'b0;

  uart_imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .HDR_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .start(start),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .err(err), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  // Records one comparison and reports it if it fails
  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advances n cycles; the bench always drives 2 time units after a rising edge
  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Sends one UART byte, LSB first, with a chosen stop-bit level
  task automatic apply_stimulus(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_cycles(CPB);
    end
    rxd = stop_bit;
    wait_cycles(CPB);
    rxd = 1'b1;
    wait_cycles(4);
  endtask

  task automatic send_bytes(input byte_q_t b);
    foreach (b[i]) apply_stimulus(b[i], 1'b1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    wait_cycles(1);
    start = 1'b0;
  endtask

  // Number of words a load writes for a count byte n
  function automatic int model_target(input int n);
    return (n == 0 || n > DEPTH) ? DEPTH : n;
  endfunction

  // Queues the writes for data bytes d under count byte n. Only complete words
  // are queued.
  task automatic expect_load(input logic [7:0] n, input byte_q_t d);
    int t;
    t = model_target(int'(n));
    for (int k = 0; k < t; k++) begin
      if (4 * k + 3 < d.size())
        exp_q.push_back({k[AW-1:0], d[4*k], d[4*k+1], d[4*k+2], d[4*k+3]});
    end
  endtask

  task automatic random_bytes(input int n, output byte_q_t d);
    d = {};
    for (int i = 0; i < n; i++) d.push_back(8'($urandom));
  endtask

  // Waits for the load to finish, with a bound
  task automatic wait_settled();
    int cyc;
    cyc = 0;
    while (!(done || err) && cyc < 400) begin
      wait_cycles(1);
      cyc++;
    end
    check_output("settle", {31'd0, done | err}, 32'd1);
  endtask

  task automatic check_loaded(input int n);
    check_output("done", {31'd0, done}, 32'd1);
    check_output("err_clear", {31'd0, err}, 32'd0);
    check_output("cpu_hold_released", {31'd0, cpu_hold}, 32'd0);
    check_output("word_cnt", {25'd0, word_cnt}, 32'(n));
    check_output("writes_outstanding", 32'(exp_q.size()), 32'd0);
  endtask

  // Every write pulse must match the next queued write. The write must have
  // the CPU held and be a single cycle. word_cnt still shows the words written
  // before this one.
  always @(negedge clk) begin : compare
    wr_t e;
    if (rst) begin
      if (wr_en) begin
        check_output("wr_pulse_width", {31'd0, prev_wr_en}, 32'd0);
        if (exp_q.size() == 0) begin
          check_output("unexpected_write", {31'd0, wr_en}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_output("wr_addr", {26'd0, wr_addr}, {26'd0, e.addr});
          check_output("wr_data", wr_data, e.data);
          check_output("word_cnt_at_write", {25'd0, word_cnt}, {26'd0, e.addr});
          check_output("hold_at_write", {31'd0, cpu_hold}, 32'd1);
        end
      end
      prev_wr_en = wr_en;
    end else begin
      prev_wr_en = 1'b0;
    end
  end

  initial begin : watchdog
    #1_200_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    byte_q_t d, f;
    logic [7:0] n;
    rst = 1'b1; rxd = 1'b1; start = 1'b0;
    #3 rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_output("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check_output("rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    check_output("rst_done", {31'd0, done}, 32'd0);
    check_output("rst_err", {31'd0, err}, 32'd0);
    check_output("rst_word_cnt", {25'd0, word_cnt}, 32'd0);
    check_output("rst_wr_addr", {26'd0, wr_addr}, 32'd0);
    check_output("rst_wr_data", wr_data, 32'd0);
    rst = 1'b1;
    wait_cycles(1000);
    check_output("idle_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    check_output("idle_done", {31'd0, done}, 32'd0);
    check_output("idle_word_cnt", {25'd0, word_cnt}, 32'd0);

    // Single-word load, literal expectations
    $display("[TB] single-word load");
    pulse_start();
    check_output("hold_after_start", {31'd0, cpu_hold}, 32'd1);
    exp_q.push_back({6'd0, 32'h20080005});
    send_bytes('{8'hA5, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05});
    wait_settled();
    check_loaded(1);
    check_output("wr_addr_after_one", {26'd0, wr_addr}, 32'd1);

    // Header hunt with junk bytes before the sync byte
    $display("[TB] header hunt, three words");
    pulse_start();
    random_bytes(12, d);
    expect_load(8'h03, d);
    send_bytes('{8'h00, 8'hFF, 8'hA5, 8'h03});
    send_bytes(d);
    wait_settled();
    check_loaded(3);

    // Random short loads with random junk in front of the header
    for (int it = 0; it < 2; it++) begin
      n = 8'($urandom_range(1, 5));
      $display("[TB] random load of %0d words", n);
      pulse_start();
      f = {};
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) f.push_back(8'($urandom_range(0, 8'hA4)));
      f.push_back(8'hA5);
      f.push_back(n);
      random_bytes(4 * int'(n), d);
      expect_load(n, d);
      send_bytes(f);
      send_bytes(d);
      wait_settled();
      check_loaded(int'(n));
    end

    // N=0 means a full 64-word image
    $display("[TB] full image");
    pulse_start();
    random_bytes(4 * DEPTH, d);
    expect_load(8'h00, d);
    send_bytes('{8'hA5, 8'h00});
    send_bytes(d);
    wait_settled();
    check_loaded(64);
    check_output("wr_addr_no_wrap", {26'd0, wr_addr}, 32'd63);

    // Framing error on the 3rd data byte
    $display("[TB] framing error");
    pulse_start();
    send_bytes('{8'hA5, 8'h02, 8'h11, 8'h22});
    apply_stimulus(8'h33, 1'b0);
    wait_cycles(30);
    check_output("ferr_err", {31'd0, err}, 32'd1);
    check_output("ferr_hold", {31'd0, cpu_hold}, 32'd1);
    check_output("ferr_done", {31'd0, done}, 32'd0);
    send_bytes('{8'h44, 8'h55});
    check_output("ferr_sticky", {31'd0, err}, 32'd1);
    pulse_start();
    check_output("restart_err_clear", {31'd0, err}, 32'd0);
    check_output("restart_hold", {31'd0, cpu_hold}, 32'd1);
    random_bytes(4, d);
    expect_load(8'h01, d);
    send_bytes('{8'hA5, 8'h01});
    send_bytes(d);
    wait_settled();
    check_loaded(1);

    // A 3-cycle low pulse mid-word must not add a byte
    $display("[TB] start-bit glitch");
    pulse_start();
    random_bytes(4, d);
    expect_load(8'h01, d);
    send_bytes('{8'hA5, 8'h01, d[0], d[1]});
    rxd = 1'b0;
    wait_cycles(3);
    rxd = 1'b1;
    wait_cycles(40);
    send_bytes('{d[2], d[3]});
    wait_settled();
    check_loaded(1);

    // Async reset in the middle of WAIT_DATA
    $display("[TB] async reset mid-load");
    pulse_start();
    random_bytes(5, d);
    expect_load(8'h02, d);
    send_bytes('{8'hA5, 8'h02});
    send_bytes(d);
    check_output("pre_rst_word_cnt", {25'd0, word_cnt}, 32'd1);
    check_output("pre_rst_hold", {31'd0, cpu_hold}, 32'd1);
    #1 rst = 1'b0;
    #1;
    check_output("async_rst_hold", {31'd0, cpu_hold}, 32'd0);
    check_output("async_rst_word_cnt", {25'd0, word_cnt}, 32'd0);
    check_output("async_rst_done", {31'd0, done}, 32'd0);
    wait_cycles(2);
    rst = 1'b1;
    wait_cycles(2);
    // Bytes with no start armed are ignored
    send_bytes('{8'hA5, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04});
    wait_cycles(10);
    check_output("idle_bytes_done", {31'd0, done}, 32'd0);
    check_output("idle_bytes_hold", {31'd0, cpu_hold}, 32'd0);
    check_output("idle_bytes_writes", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_imem_loader.md
Name: uart_imem_loader

Overview:
Serial boot loader that sits directly upstream of the instruction memory read by the PC/fetch stage. It receives a framed program image over a UART line and assembles it into 32-bit big-endian words. It writes those words into the instruction RAM write port and holds the CPU in reset while loading is in progress. When loading finishes, the CPU is released and fetch restarts at address 0.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); must be at least 4.
ADDR_W, 6, instruction RAM word-address width (64 words, matching the 6-bit fetch address).
HDR_BYTE, 8'hA5, sync byte that opens a load frame.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
rxd  input  1  UART receive line, idle high, asynchronous to clk.
start  input  1  one-cycle pulse that arms the loader.
wr_en  output  1  instruction RAM write strobe, one-cycle pulse.
wr_addr  output  ADDR_W  instruction RAM word address.
wr_data  output  32  instruction word to write.
cpu_hold  output  1  holds the CPU in reset (OR'd into the CPU rst) while high.
done  output  1  load completed successfully; sticky until next start or reset.
err  output  1  framing error; sticky until next start or reset.
word_cnt  output  ADDR_W+1  number of words written in the current load.

Behaviour:
- Reset (rst=0, async): all outputs 0, FSM enters IDLE, receiver enters RX_IDLE, sync flops set to 1.
- Receiver front end:
  - rxd passes through a 2-flop synchronizer.
  - A start is detected on a synced 1->0 transition while in RX_IDLE.
  - Mid-start sample at CLKS_PER_BIT/2; if the line is high, the start is treated as a glitch and the receiver returns to RX_IDLE.
  - 8 data bits are sampled every CLKS_PER_BIT, LSB first.
  - The stop bit is sampled; stop=1 gives a one-cycle byte_valid. stop=0 raises frame_err, with no byte_valid.
  - The receiver returns to RX_IDLE after the stop sample.
- Loader FSM states: IDLE, WAIT_HDR, WAIT_CNT, WAIT_DATA, WRITE, DONE, ERR.
  - IDLE/DONE/ERR + start: go to WAIT_HDR. Set cpu_hold=1, clear done/err/word_cnt, wr_addr=0.
  - start in any other state is ignored.
  - WAIT_HDR: a byte equal to HDR_BYTE goes to WAIT_CNT. Any other byte is discarded, and the FSM stays in WAIT_HDR.
  - WAIT_CNT: the byte N sets the target word count. N=0 means 2^ADDR_W. N > 2^ADDR_W is clamped to 2^ADDR_W. Then go to WAIT_DATA with byte index=0.
  - WAIT_DATA: each byte shifts into wr_data from the LSB side, so the first byte ends up in [31:24]. After the 4th byte, go to WRITE on the next cycle.
  - WRITE: wr_en=1 for exactly one cycle with the current wr_addr/wr_data.
    - Next cycle: wr_addr+1 and word_cnt+1.
    - If word_cnt reaches the target count, go to DONE; otherwise return to WAIT_DATA.
  - Write latency: wr_en rises 2 cycles after byte_valid of a word's 4th byte.
  - DONE: cpu_hold=0, done=1.
  - frame_err in WAIT_HDR, WAIT_CNT or WAIT_DATA goes to ERR. ERR sets err=1 and keeps cpu_hold=1, so the CPU is not run on a partial image. A partially assembled word is discarded.
  - A frame_err in IDLE or DONE is ignored.
- wr_addr does not wrap during a load: the clamped count guarantees the last write is at address 2^ADDR_W-1. wr_addr returns to 0 only on start.
- Bytes arriving in IDLE, DONE or ERR are ignored. Bytes arriving during the WRITE cycle cannot occur, because the byte period is much longer than the 1-cycle WRITE.
- Reset mid-load: immediate return to IDLE with cpu_hold=0. RAM contents are left as partially written; no cleanup is performed.
- wr_data holds its last value outside WRITE. Memory must only use it when wr_en=1.

Test Plan:
- Reset then idle: rst=0 for 3 cycles, rxd=1 -> wr_en=0, cpu_hold=0, done=0, err=0, word_cnt=0; no activity for 1000 cycles.
- Single-word load (CLKS_PER_BIT=16): start, then bytes A5,01,20,08,00,05 -> one wr_en pulse with wr_addr=0, wr_data=32'h20080005; then done=1, cpu_hold=0, word_cnt=1.
- Header hunt plus multi-word load: start, then bytes 00,FF,A5,03 followed by 12 data bytes -> junk ignored; three writes at addresses 0,1,2 with the correct big-endian words; done=1.
- N=0 full image: start, A5,00, 256 bytes -> 64 writes at addresses 0..63; word_cnt=64; wr_addr never wraps before done.
- Framing error: start, A5,02, then the 3rd data byte sent with stop=0 -> err=1, cpu_hold stays 1, no further writes; a new start clears err and a following good frame loads correctly.
- Start-bit glitch and async reset: a 3-cycle low pulse on rxd produces no byte. Asserting rst low mid-WAIT_DATA -> FSM returns to IDLE, cpu_hold=0, word_cnt=0 immediately without waiting for a clock edge.
